// File: rtl/csr_pkg.sv
// Shared CSR definitions: access opcodes, counter-related CSR addresses
// and the read-modify-write helper used by every writable CSR.
package csr_pkg;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        SET   = 2'd2,
        CLEAR = 2'd3
    } op_t;

    typedef enum logic [11:0] {
        MCOUNTINHIBIT  = 12'h320,
        MHPMEVENT3     = 12'h323,
        MHPMEVENT31    = 12'h33F,
        MCYCLE         = 12'hB00,
        MINSTRET       = 12'hB02,
        MHPMCOUNTER3   = 12'hB03,
        MHPMCOUNTER31  = 12'hB1F,
        MCYCLEH        = 12'hB80,
        MINSTRETH      = 12'hB82,
        MHPMCOUNTER3H  = 12'hB83,
        MHPMCOUNTER31H = 12'hB9F
    } csr_t;

    localparam int unsigned INH_CY = 0;
    localparam int unsigned INH_IR = 2;

    function automatic logic [31:0] apply_op(op_t op, logic [31:0] old_v, logic [31:0] wdata);
        case (op)
            WRITE:   return wdata;
            SET:     return old_v | wdata;
            CLEAR:   return old_v & ~wdata;
            default: return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_counters_hpm_counter64.sv
// One 64-bit event counter. A write to either half suppresses that cycle's
// increment for the whole counter; the carry crosses halves in one cycle.
module hpm_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assigning the default first means every path drives cnt_d, so no latch is inferred.
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_counters.sv
// Machine-mode counter CSRs: mcycle, minstret, NUM_HPM mhpmcounters with
// event selectors, and mcountinhibit. Read data is registered one cycle.
module csr_counters
    import csr_pkg::*;
#(
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned NUM_EVENTS = 8,
    parameter int unsigned EVT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_req_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [1:0]            csr_op_i,
    input  logic [31:0]           csr_wdata_i,
    output logic                  csr_rvalid_o,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_err_o,
    input  logic                  retire_i,
    input  logic [NUM_EVENTS-1:0] event_i
);

    localparam int unsigned NUM_CNT   = 2 + NUM_HPM;
    localparam logic [31:0] INH_MASK  = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    // Counter index 0 is mcycle, 1 is minstret, 2+i is mhpmcounter(3+i).
    logic [63:0]        cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc, cnt_wr_lo, cnt_wr_hi;

    logic [EVT_W-1:0]   evt_q [NUM_HPM];
    logic [NUM_HPM-1:0] evt_wr;
    logic [31:0]        inh_q, inh_d;
    logic               inh_wr;

    logic [31:0]        old_val, new_val;
    logic               acc_err, do_write;
    op_t                op;

    logic               rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    function automatic logic [EVT_W-1:0] evt_warl(logic [EVT_W-1:0] v);
        return (32'(v) > NUM_EVENTS) ? '0 : v;
    endfunction

    assign op = op_t'(csr_op_i);

    always_comb begin
        old_val   = '0;
        acc_err   = 1'b0;
        cnt_wr_lo = '0;
        cnt_wr_hi = '0;
        evt_wr    = '0;
        inh_wr    = 1'b0;
        if (csr_addr_i == MCYCLE) begin
            old_val      = cnt_val[0][31:0];
            cnt_wr_lo[0] = 1'b1;
        end else if (csr_addr_i == MCYCLEH) begin
            old_val      = cnt_val[0][63:32];
            cnt_wr_hi[0] = 1'b1;
        end else if (csr_addr_i == MINSTRET) begin
            old_val      = cnt_val[1][31:0];
            cnt_wr_lo[1] = 1'b1;
        end else if (csr_addr_i == MINSTRETH) begin
            old_val      = cnt_val[1][63:32];
            cnt_wr_hi[1] = 1'b1;
        end else if (csr_addr_i == MCOUNTINHIBIT) begin
            old_val = inh_q;
            inh_wr  = 1'b1;
        end else if (csr_addr_i >= MHPMCOUNTER3 && csr_addr_i <= MHPMCOUNTER31) begin
            // Unimplemented counters in the range fall through as read-zero.
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_addr_i[4:0] == 5'(i + 3)) begin
                    old_val          = cnt_val[2+i][31:0];
                    cnt_wr_lo[2+i]   = 1'b1;
                end
            end
        end else if (csr_addr_i >= MHPMCOUNTER3H && csr_addr_i <= MHPMCOUNTER31H) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_addr_i[4:0] == 5'(i + 3)) begin
                    old_val          = cnt_val[2+i][63:32];
                    cnt_wr_hi[2+i]   = 1'b1;
                end
            end
        end else if (csr_addr_i >= MHPMEVENT3 && csr_addr_i <= MHPMEVENT31) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_addr_i[4:0] == 5'(i + 3)) begin
                    old_val   = 32'(evt_q[i]);
                    evt_wr[i] = 1'b1;
                end
            end
        end else begin
            acc_err = 1'b1;
        end
    end

    assign do_write = csr_req_i && !acc_err && (op != READ);
    assign new_val  = apply_op(op, old_val, csr_wdata_i);

    always_comb begin
        cnt_inc    = '0;
        cnt_inc[0] = ~inh_q[INH_CY];
        cnt_inc[1] = retire_i & ~inh_q[INH_IR];
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if (evt_q[i] == EVT_W'(k)) begin
                    cnt_inc[2+i] = event_i[k-1] & ~inh_q[3+i];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        hpm_counter64 u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (cnt_inc[k]),
            .wr_lo_i (cnt_wr_lo[k] & do_write),
            .wr_hi_i (cnt_wr_hi[k] & do_write),
            .wdata_i (new_val),
            .value_o (cnt_val[k])
        );
    end

    always_comb begin
        inh_d    = (inh_wr && do_write) ? (new_val & INH_MASK) : inh_q;
        rvalid_d = csr_req_i;
        rdata_d  = csr_req_i ? old_val : '0;
        err_d    = csr_req_i & acc_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            // NOTE: the selector array is architectural state with a defined reset value, so each entry is cleared.
            for (int i = 0; i < NUM_HPM; i++) begin
                evt_q[i] <= '0;
            end
        end else begin
            inh_q    <= inh_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            for (int i = 0; i < NUM_HPM; i++) begin
                if (evt_wr[i] && do_write) begin
                    evt_q[i] <= evt_warl(new_val[EVT_W-1:0]);
                end
            end
        end
    end

    assign csr_rvalid_o = rvalid_q;
    assign csr_rdata_o  = rdata_q;
    assign csr_err_o    = err_q;

endmodule

// File: tb/tb_csr_counters.sv
// Scoreboard bench for csr_counters: directed scenarios then random traffic,
// checked against a cycle-level reference model of the counter CSRs.
module tb_csr_counters;
    import csr_pkg::*;

    localparam int NUM_HPM    = 4;
    localparam int NUM_EVENTS = 8;
    localparam int EVT_W      = 5;
    localparam int NUM_CNT    = 2 + NUM_HPM;

    localparam int K_ERR  = 0;
    localparam int K_LO   = 1;
    localparam int K_HI   = 2;
    localparam int K_INH  = 3;
    localparam int K_EVT  = 4;
    localparam int K_ZERO = 5;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  csr_req_i;
    logic [11:0]           csr_addr_i;
    logic [1:0]            csr_op_i;
    logic [31:0]           csr_wdata_i;
    logic                  csr_rvalid_o;
    logic [31:0]           csr_rdata_o;
    logic                  csr_err_o;
    logic                  retire_i;
    logic [NUM_EVENTS-1:0] event_i;

    csr_counters #(.NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS), .EVT_W(EVT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_req_i    (csr_req_i),
        .csr_addr_i   (csr_addr_i),
        .csr_op_i     (csr_op_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rvalid_o (csr_rvalid_o),
        .csr_rdata_o  (csr_rdata_o),
        .csr_err_o    (csr_err_o),
        .retire_i     (retire_i),
        .event_i      (event_i)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q[$];

    // Reference state
    longint unsigned m_cnt [NUM_CNT];
    int unsigned     m_sel [NUM_HPM];
    int unsigned     m_inh;
    int unsigned     inh_mask = 32'h5 | (((2 ** NUM_HPM) - 1) << 3);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [11:0] a, output int kind, output int idx);
        int unsigned off;
        kind = K_ERR;
        idx  = 0;
        if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
            off = a % 32;
            if (off == 1) kind = K_ERR;
            else if (off >= 3 && off >= 3 + NUM_HPM) kind = K_ZERO;
            else begin
                kind = (a >= 12'hB80) ? K_HI : K_LO;
                idx  = (off == 0) ? 0 : (off == 2) ? 1 : int'(off) - 1;
            end
        end else if (a == 12'h320) begin
            kind = K_INH;
        end else if (a >= 12'h323 && a <= 12'h33F) begin
            off = a - 12'h320;
            if (off >= 3 + NUM_HPM) kind = K_ZERO;
            else begin
                kind = K_EVT;
                idx  = int'(off) - 3;
            end
        end
    endfunction

    // Advances the model by one clock edge with the given inputs.
    task automatic model_cycle(input bit r, input bit req, input logic [11:0] a, input logic [1:0] op,
                               input logic [31:0] wd, input bit ret, input logic [NUM_EVENTS-1:0] ev,
                               output bit push, output rsp_t rsp);
        int          kind, idx;
        logic [31:0] oldv, newv;
        bit          wr;
        bit          inc [NUM_CNT];
        int unsigned nsel;
        push = req && !r;
        rsp  = '0;
        if (r) begin
            foreach (m_cnt[c]) m_cnt[c] = 0;
            foreach (m_sel[i]) m_sel[i] = 0;
            m_inh = 0;
            return;
        end
        decode(a, kind, idx);
        oldv = 32'h0;
        if (kind == K_LO) oldv = 32'(m_cnt[idx]);
        else if (kind == K_HI) oldv = 32'(m_cnt[idx] >> 32);
        else if (kind == K_INH) oldv = m_inh;
        else if (kind == K_EVT) oldv = m_sel[idx];
        rsp.err  = (kind == K_ERR);
        rsp.data = oldv;
        wr = req && (kind != K_ERR) && (kind != K_ZERO) && (op != READ);
        if (op == WRITE) newv = wd;
        else if (op == SET) newv = oldv | wd;
        else newv = oldv & ~wd;
        inc[0] = ((m_inh >> 0) & 1) == 0;
        inc[1] = ret && ((m_inh >> 2) & 1) == 0;
        for (int i = 0; i < NUM_HPM; i++)
            inc[2+i] = (m_sel[i] != 0) && ev[m_sel[i]-1] && ((m_inh >> (3 + i)) & 1) == 0;
        for (int c = 0; c < NUM_CNT; c++) begin
            if (wr && kind == K_LO && idx == c)
                m_cnt[c] = (m_cnt[c] & 64'hFFFF_FFFF_0000_0000) | 64'(newv);
            else if (wr && kind == K_HI && idx == c)
                m_cnt[c] = (m_cnt[c] & 64'h0000_0000_FFFF_FFFF) | {newv, 32'h0};
            else if (inc[c])
                m_cnt[c] = m_cnt[c] + 1;
        end
        if (wr && kind == K_INH) m_inh = newv & inh_mask;
        if (wr && kind == K_EVT) begin
            nsel = newv % (2 ** EVT_W);
            m_sel[idx] = (nsel > NUM_EVENTS) ? 0 : nsel;
        end
    endtask

    // Drives one cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit req, input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] wd, input bit ret, input logic [NUM_EVENTS-1:0] ev);
        bit   push;
        rsp_t rsp;
        csr_req_i   = req;
        csr_addr_i  = a;
        csr_op_i    = op;
        csr_wdata_i = wd;
        retire_i    = ret;
        event_i     = ev;
        @(posedge clk);
        model_cycle(rst, req, a, op, wd, ret, ev, push, rsp);
        if (push) exp_q.push_back(rsp);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 12'h0, READ, 32'h0, 1'b0, '0);
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(1'b1, a, READ, 32'h0, 1'b0, '0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        cycle(1'b1, a, op, wd, 1'b0, '0);
    endtask

    // Monitor: a response is owed exactly when the scoreboard holds one.
    rsp_t mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("rvalid", 64'(csr_rvalid_o), 64'd1);
                if (csr_rvalid_o === 1'b1) begin
                    check("rdata", 64'(csr_rdata_o), 64'(mon_exp.data));
                    check("err", 64'(csr_err_o), 64'(mon_exp.err));
                end
            end else begin
                check("rvalid_idle", 64'(csr_rvalid_o), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] addr_pool [] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
                                   12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB07, 12'hB1F,
                                   12'hB9F, 12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327,
                                   12'h33F, 12'hB01, 12'h321, 12'h7C0};

    initial begin
        logic [11:0]           ra;
        logic [31:0]           rw;
        logic [NUM_EVENTS-1:0] rev;
        int                    sel;

        // Reset held with a request pending: no response may follow.
        rst = 1'b1;
        cycle(1'b1, MCYCLE, READ, 32'h0, 1'b0, '0);
        cycle(1'b1, MINSTRET, WRITE, 32'h55, 1'b1, '1);
        check("reset_rvalid", 64'(csr_rvalid_o), 64'd0);
        check("reset_rdata", 64'(csr_rdata_o), 64'd0);
        check("reset_err", 64'(csr_err_o), 64'd0);
        rst = 1'b0;

        idle(10);
        rd(MCYCLE);
        rd(MINSTRET);

        // Carry from the low to the high half.
        wr(MCYCLEH, WRITE, 32'h0);
        wr(MCYCLE, WRITE, 32'hFFFF_FFFE);
        idle(2);
        rd(MCYCLE);
        rd(MCYCLEH);

        // Event selection and WARL on the selector.
        wr(MHPMEVENT3, WRITE, 32'd2);
        for (int i = 0; i < 5; i++) cycle(1'b0, 12'h0, READ, 32'h0, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, READ, 32'h0, 1'b0, 8'h01);
        rd(MHPMCOUNTER3);
        wr(MHPMEVENT3, WRITE, 32'd31);
        rd(MHPMEVENT3);

        // Inhibit cycle and instret counting.
        wr(MCOUNTINHIBIT, SET, 32'h5);
        rd(MINSTRET);
        rd(MCYCLE);
        for (int i = 0; i < 20; i++) cycle(1'b0, 12'h0, READ, 32'h0, 1'b1, '0);
        rd(MINSTRET);
        rd(MCYCLE);
        rd(MCOUNTINHIBIT);
        wr(MCOUNTINHIBIT, CLEAR, 32'h1);
        rd(MCYCLE);
        rd(MCYCLE);

        // Write beats a coincident retire.
        cycle(1'b1, MINSTRET, WRITE, 32'h100, 1'b1, '0);
        rd(MINSTRET);

        // Illegal and unimplemented addresses.
        rd(12'h7C0);
        rd(MHPMCOUNTER31);
        wr(MHPMCOUNTER31, WRITE, 32'hDEAD);
        rd(MHPMEVENT31);

        // Reset mid-run with a request pending.
        rst = 1'b1;
        rd(MCYCLE);
        rst = 1'b0;
        rd(MCYCLE);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            ra  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, addr_pool.size() - 1)];
            sel = $urandom_range(0, 2);
            rw  = (sel == 0) ? $urandom : (sel == 1) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 31);
            rev = NUM_EVENTS'($urandom);
            cycle($urandom_range(0, 1) == 1, ra, 2'($urandom_range(0, 3)), rw, $urandom_range(0, 1) == 1, rev);
        end
        rst = 1'b0;

        idle(3);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_counters.md
Name: csr_counters

Overview:
- Machine-mode counter unit for the core's CSR path. It implements mcycle, minstret, NUM_HPM programmable mhpmcounters with their mhpmevent selectors, and mcountinhibit.
- It takes CSR accesses decoded against the csr::t address enum from the CSR access stage and returns read data one cycle later.
- It counts retire and pipeline events driven by the execute/writeback stages.

Parameters:
- NUM_HPM, 4, number of implemented HPM counters, mapped to mhpmcounter3..3+NUM_HPM-1 (range 0..29).
- NUM_EVENTS, 8, width of the event_i vector. Event selector value k (1..NUM_EVENTS) counts event_i[k-1]; value 0 counts nothing.
- EVT_W, 5, implemented width of each mhpmevent register.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- csr_req_i  in  1  CSR access valid this cycle
- csr_addr_i  in  12  CSR address (csr::t encoding)
- csr_op_i  in  2  csr_pkg::op_t: READ, WRITE, SET, CLEAR
- csr_wdata_i  in  32  write/set/clear operand
- csr_rvalid_o  out  1  response valid (one cycle after request)
- csr_rdata_o  out  32  old CSR value
- csr_err_o  out  1  access fault (valid with csr_rvalid_o)
- retire_i  in  1  one instruction retired this cycle
- event_i  in  NUM_EVENTS  per-cycle event pulses

Behaviour:
Reset:
- csr_rvalid_o=0, csr_rdata_o=0, csr_err_o=0.
- All counters=0, all mhpmevent=0, mcountinhibit=0.
- A reset asserted coincident with a request discards that request; no response follows.

Access handshake:
- No backpressure; a request is accepted every cycle it is asserted.
- The response is registered: csr_rvalid_o is high exactly one cycle after csr_req_i, with csr_rdata_o holding the pre-write value.
- Back-to-back requests give back-to-back responses. A read in cycle N+1 of a register written in cycle N returns the written value.

Write value:
- WRITE: new = wdata.
- SET: new = old | wdata.
- CLEAR: new = old & ~wdata.
- The write commits at the end of the request cycle.

Address map:
- MCYCLE/MCYCLEH and MINSTRET/MINSTRETH: low and high halves of 64-bit counters.
- MHPMCOUNTERn/nH and MHPMEVENTn for implemented n: read/write.
- MHPMCOUNTERn, MHPMEVENTn for unimplemented n (up to 31): read 0, writes ignored, no error.
- MCOUNTINHIBIT (0x320): bit0 CY, bit2 IR, bit n HPMn for implemented n. Bit1 and unimplemented bits are hardwired 0.
- Any other address: csr_err_o=1, rdata=0, no state change.

mhpmevent write rule (WARL):
- Only the low EVT_W bits are stored.
- A stored value > NUM_EVENTS becomes 0.

Counting (each cycle, per counter):
- mcycle: +1 unless CY inhibited.
- minstret: +retire_i unless IR inhibited.
- mhpmcounter n: +event_i[sel-1] if sel != 0 and not inhibited.
- 64-bit wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0; the carry crosses the 32-bit halves in the same cycle.

Simultaneous events:
- A CSR write to either half of a counter in the same cycle as an increment: the write wins, and the whole counter does not increment that cycle. The written half takes the new value; the other half holds.
- A write to mcountinhibit takes effect from the next cycle.
- A write to mhpmevent switches the selected event from the next cycle.

Decomposition:
- csr_pkg additions:
  - op_t enum {READ, WRITE, SET, CLEAR}.
  - MCOUNTINHIBIT = 12'h320 added to csr::t.
  - constants INH_CY=0, INH_IR=2.
- One sub-module: hpm_counter64.
  - Holds one 64-bit counter with inc_i, wr_lo_i, wr_hi_i, wdata_i and value_o.
  - Write-beats-increment is applied inside it.
  - Instantiated 2+NUM_HPM times.

Test Plan:
- Reset, then 10 idle cycles, then read MCYCLE → rdata=10 ±1 (pipeline-aligned exact value fixed by the bench); MINSTRET reads 0; rvalid exactly 1 cycle after req.
- WRITE MCYCLEH=0 and MCYCLE=0xFFFF_FFFE on consecutive cycles, then wait 2 cycles → MCYCLE=0x0000_0000 and MCYCLEH=1 (carry across halves).
- WRITE MHPMEVENT3=2, pulse event_i[1] 5 times and event_i[0] 3 times → MHPMCOUNTER3=5; WRITE MHPMEVENT3=31 then read → 0.
- SET MCOUNTINHIBIT=0x5, hold retire_i=1 for 20 cycles → MINSTRET and MCYCLE unchanged; read MCOUNTINHIBIT → 0x5; CLEAR 0x1 → mcycle resumes the next cycle.
- WRITE MINSTRET=0x100 in a cycle with retire_i=1 → the next read returns 0x100, not 0x101.
- Read 0x7C0 → csr_err_o=1, rdata=0. Read MHPMCOUNTER31 with NUM_HPM=4 → rdata=0, err=0. Assert rst with a request pending → no rvalid the next cycle.
